// File: rtl/bfly7681_pkg.sv
// Shared constants and the single-step centred reduction for the Q = 7681 NTT datapath.
// The modmul and inverse-butterfly blocks reuse red1.
package bfly7681_pkg;
    localparam int Q       = 7681;
    localparam int HALF_Q  = 3840;
    localparam int COEF_W  = 13;
    localparam int PROD_W  = 25;
    localparam int MUL_LAT = 3;

    localparam logic signed [COEF_W:0] Q_S      = 14'sd7681;
    localparam logic signed [COEF_W:0] HALF_Q_S = 14'sd3840;

    // Input range is [-2*HALF_Q, 2*HALF_Q], so one conditional correction always lands in range.
    function automatic logic signed [COEF_W-1:0] red1(input logic signed [COEF_W:0] x);
        logic signed [COEF_W:0] r;
        if (x > HALF_Q_S)
            r = x - Q_S;
        else if (x < -HALF_Q_S)
            r = x + Q_S;
        else
            r = x;
        return r[COEF_W-1:0];
    endfunction
endpackage

// File: rtl/bfly7681_delay.sv
// DEPTH x WIDTH shift register with asynchronous clear; taps exposes every stage (newest in the low word).
module bfly7681_delay #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 13
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [DEPTH*WIDTH-1:0] taps
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            taps <= '0;
        else
            taps <= {taps[(DEPTH-1)*WIDTH-1:0], din};
    end

    assign dout = taps[DEPTH*WIDTH-1 -: WIDTH];
endmodule

// File: rtl/bfly7681_ct.sv
// Cooley-Tukey butterfly around the external modmul7681s: registers b*w into the modmul,
// then pairs the reduced product with the delay-aligned a to emit (a+wb, a-wb) mod 7681.
module bfly7681_ct
    import bfly7681_pkg::*;
#(
    parameter int BATCH = 256,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [12:0]       in_a,
    input  logic signed [12:0]       in_b,
    input  logic signed [12:0]       in_w,
    output logic signed [24:0]       mul_z,
    input  logic signed [12:0]       mul_c,
    output logic                     out_valid,
    output logic signed [12:0]       out_p,
    output logic signed [12:0]       out_m,
    output logic                     out_last,
    output logic [CNT_W-1:0]         out_cnt,
    output logic                     busy
);
    localparam int ALIGN = 1 + MUL_LAT;

    // Valid-only stream: in_valid qualifies a/b/w for one cycle, there is no ready and no stall;
    // out_valid marks out_p/out_m exactly 2+MUL_LAT cycles later.
    logic signed [PROD_W-1:0]  prod;
    logic signed [COEF_W-1:0]  aAligned;
    logic [0:0]                vAligned;
    logic [ALIGN-1:0]          vTaps;
    logic [ALIGN*COEF_W-1:0]   unusedATaps;
    logic signed [COEF_W:0]    sumW;
    logic signed [COEF_W:0]    difW;

    // |b*w| < 2^24, so a 25-bit product is exact.
    assign prod = PROD_W'(in_b) * PROD_W'(in_w);

    bfly7681_delay #(.DEPTH(ALIGN), .WIDTH(COEF_W)) aDelay (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (in_a),
        .dout (aAligned),
        .taps (unusedATaps)
    );

    bfly7681_delay #(.DEPTH(ALIGN), .WIDTH(1)) vDelay (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (in_valid),
        .dout (vAligned),
        .taps (vTaps)
    );

    assign sumW = {aAligned[COEF_W-1], aAligned} + {mul_c[COEF_W-1], mul_c};
    assign difW = {aAligned[COEF_W-1], aAligned} - {mul_c[COEF_W-1], mul_c};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_z     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_p     <= '0;
            out_m     <= '0;
            out_cnt   <= '0;
        end else begin
            mul_z     <= prod;
            out_valid <= vAligned[0];
            out_last  <= vAligned[0] && (out_cnt == CNT_W'(BATCH - 1));
            if (vAligned[0]) begin
                out_p   <= red1(sumW);
                out_m   <= red1(difW);
                out_cnt <= (out_cnt == CNT_W'(BATCH - 1)) ? '0 : out_cnt + 1'b1;
            end
        end
    end

    assign busy = (|vTaps) | out_valid;
endmodule

// File: tb/tb_bfly7681_ct.sv
// Bench for bfly7681_ct with a behavioural 3-stage modmul7681s in the loop.
module tb_bfly7681_ct;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic signed [12:0] in_a, in_b, in_w;
    logic signed [24:0] mul_z;
    logic signed [12:0] mul_c = '0;
    logic signed [12:0] mm1 = '0, mm2 = '0;
    logic               out_valid;
    logic signed [12:0] out_p, out_m;
    logic               out_last;
    logic [7:0]         out_cnt;
    logic               busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int mon_k = 0;
    logic [57:0] exp_q[$];

    bfly7681_ct dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_w     (in_w),
        .mul_z    (mul_z),
        .mul_c    (mul_c),
        .out_valid(out_valid),
        .out_p    (out_p),
        .out_m    (out_m),
        .out_last (out_last),
        .out_cnt  (out_cnt),
        .busy     (busy)
    );

    // clock / cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cmod(input int x);
        int r;
        r = x % 7681;
        if (r > 3840) r -= 7681;
        else if (r < -3840) r += 7681;
        return r;
    endfunction

    // modmul7681s model: mul_c valid MUL_LAT=3 cycles after mul_z
    always @(posedge clk) begin
        mm1   <= 13'(cmod(int'(mul_z)));
        mm2   <= mm1;
        mul_c <= mm2;
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // driver tasks
    task automatic send(input int a, input int b, input int w,
                        input bit hand, input int hp, input int hm);
        int p, m;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_a = 13'(a);
        in_b = 13'(b);
        in_w = 13'(w);
        if (hand) begin
            p = hp;
            m = hm;
        end else begin
            p = cmod(a + b * w);
            m = cmod(a - b * w);
        end
        exp_q.push_back({32'(cyc + 5), 13'(p), 13'(m)});
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = 13'(int'($urandom_range(7680)) - 3840);
        in_b = 13'(int'($urandom_range(7680)) - 3840);
        in_w = 13'(int'($urandom_range(7680)) - 3840);
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 60) begin
            idle();
            i++;
        end
        idle();
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
    endtask

    function automatic int rnd();
        return int'($urandom_range(7680)) - 3840;
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        logic [57:0] e;
        if (!rst_n) begin
            mon_k = 0;
        end else if (out_valid) begin
            mon_k++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out: out_valid=1 at cycle %0d, expected 0", cyc);
            end else begin
                e = exp_q.pop_front();
                check("out_cycle", cyc, int'(e[57:26]));
                check("out_p", int'(out_p), int'($signed(e[25:13])));
                check("out_m", int'(out_m), int'($signed(e[12:0])));
                check("out_cnt", int'(out_cnt), mon_k % 256);
                check("out_last", int'(out_last), int'((mon_k % 256) == 0));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_a = 13'sd5; in_b = 13'sd7; in_w = 13'sd9;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_p", int'(out_p), 0);
        check("rst_out_m", int'(out_m), 0);
        check("rst_out_cnt", int'(out_cnt), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_mul_z", int'(mul_z), 0);
        in_valid = 1'b0;
        rst_n = 1'b1;

        // single butterfly, exact latency
        send(1, 2, 3, 1'b1, 7, -5);
        idle();
        check("busy_inflight", int'(busy), 1);
        repeat (3) idle();

        // positive and negative corrections
        send(3840, 1, 3840, 1'b1, -1, 0);
        idle();
        send(-3840, 1, 3840, 1'b1, 0, 1);
        idle();

        // largest product through the modmul
        send(0, 3840, 3840, 1'b1, -1920, 1920);
        idle();
        check("mul_z_max", int'(mul_z), 14745600);
        repeat (3) idle();
        check("mul_c_max", int'(mul_c), -1920);
        wait_drain();
        check("busy_idle", int'(busy), 0);

        // reset with three butterflies in flight
        send(rnd(), rnd(), rnd(), 1'b0, 0, 0);
        send(rnd(), rnd(), rnd(), 1'b0, 0, 0);
        send(rnd(), rnd(), rnd(), 1'b0, 0, 0);
        idle();
        check("busy_before_rst", int'(busy), 1);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_p", int'(out_p), 0);
        check("midrst_out_m", int'(out_m), 0);
        check("midrst_busy", int'(busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) idle();
        check("post_rst_cnt", int'(out_cnt), 0);
        check("post_rst_busy", int'(busy), 0);

        // 600 back-to-back butterflies, two batch boundaries
        for (int i = 0; i < 600; i++)
            send(rnd(), rnd(), rnd(), 1'b0, 0, 0);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: run still active at cycle %0d, expected completion", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
